// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int              FETCH_XLEN        = 32;
    localparam logic [31:0]     HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0]     PC_STEP           = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, memory and consumer signals of the fetch stage
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            go;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            ir_valid;
    logic            ir_ready;
    logic [XLEN-1:0] ir_out;
    logic [XLEN-1:0] ir_pc;
    logic            halted;

    modport master (
        input  go, redirect_valid, redirect_pc, imem_ack, imem_rdata, ir_ready,
        output imem_req, imem_addr, ir_valid, ir_out, ir_pc, halted
    );

    modport slave (
        output go, redirect_valid, redirect_pc, imem_ack, imem_rdata, ir_ready,
        input  imem_req, imem_addr, ir_valid, ir_out, ir_pc, halted
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small prefetch FIFO with flush, occupancy count and head view
module fetch_fifo #(
    parameter type T     = logic [63:0],
    parameter int  DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  T                       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output T                       o_head
);

    localparam int AW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC owner, single-outstanding imem requester and IR prefetch buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] w_addr_nxt;
    logic            r_req;
    logic            w_req_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            r_halted;
    logic            w_halted_nxt;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic [CW-1:0]   w_count;
    int              w_count_nxt;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    // Only one request is ever in flight, so r_req doubles as the outstanding count.
    assign w_ack        = bus.imem_ack & r_req;
    assign w_push       = w_ack & ~r_drop & ~bus.redirect_valid;
    assign w_valid      = (w_count != '0);
    assign w_pop        = w_valid & bus.ir_ready & ~bus.redirect_valid;
    assign w_push_entry = '{pc: r_fetch_pc, instr: bus.imem_rdata};

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (bus.redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_fetch_pc;
        w_addr_nxt   = r_addr;
        w_req_nxt    = r_req & ~w_ack;
        w_drop_nxt   = r_drop & ~w_ack;
        w_halted_nxt = r_halted;
        w_count_nxt  = int'(w_count) + int'(w_push) - int'(w_pop);

        if (w_push) begin
            w_pc_nxt = r_fetch_pc + PC_STEP;
        end
        if (w_pop && (w_head.instr == HALT_WORD)) begin
            w_halted_nxt = 1'b1;
        end

        unique case (r_state)
            ST_IDLE:  if (bus.go) w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_push && (bus.imem_rdata == HALT_WORD)) w_state_nxt = ST_HALT;
            default:  ;
        endcase

        // A request still in flight at redirect finishes on the bus; its data is dropped.
        if (bus.redirect_valid) begin
            w_pc_nxt     = {bus.redirect_pc[XLEN-1:2], 2'b00};
            w_count_nxt  = 0;
            w_halted_nxt = 1'b0;
            w_drop_nxt   = r_req & ~w_ack;
            if (r_state != ST_IDLE) begin
                w_state_nxt = ST_FETCH;
            end
        end

        if ((w_state_nxt == ST_FETCH) && !w_req_nxt && (w_count_nxt < FIFO_DEPTH)) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_drop     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_req      <= w_req_nxt;
            r_drop     <= w_drop_nxt;
            r_halted   <= w_halted_nxt;
        end
    end

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.ir_valid  = w_valid;
    assign bus.ir_out    = w_head.instr;
    assign bus.ir_pc     = w_head.pc;
    assign bus.halted    = r_halted;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the core's decode/execute path; produces the instruction word the core latches into its IR.
- Owns the fetch PC and issues single-outstanding word requests to instruction memory.
- Buffers returned words in a small prefetch FIFO, and delivers them to the consumer with a valid/ready handshake.
- Supports control-flow redirect with flush, and halts fetching on the halt word 32'hFFFFFFFF.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FIFO_DEPTH, 2, prefetch FIFO entries (power of 2, >=2).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- go  input  1  start fetching; sampled only in IDLE.
- redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  XLEN  new fetch address; bits [1:0] forced to 0.
- imem_req  output  1  memory request.
- imem_addr  output  XLEN  word-aligned request address.
- imem_ack  input  1  response strobe; imem_rdata valid the same cycle.
- imem_rdata  input  XLEN  fetched word.
- ir_valid  output  1  FIFO head holds an instruction.
- ir_ready  input  1  consumer accepts the head this cycle.
- ir_out  output  XLEN  head instruction word.
- ir_pc  output  XLEN  address of ir_out.
- halted  output  1  halt word has been consumed.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - FIFO empty, storage cleared; ir_valid=0, ir_out=0, ir_pc=0, halted=0.
  - Outstanding and drop flags cleared.
- Reset deassertion mid-transfer: any late imem_ack is ignored, because no request is outstanding after reset.
- States:
  - IDLE: go=1 -> FETCH.
  - FETCH: issue requests; enter HALT when HALT_WORD is pushed.
  - HALT: no new requests; redirect_valid -> FETCH.
- Request rules:
  - imem_req is registered and asserted while a request is outstanding.
  - imem_addr is stable until the request is acked.
  - A request issues only if (fifo_count + outstanding) < FIFO_DEPTH. This credit check guarantees a FIFO slot for every ack.
- Ack rules:
  - imem_ack is honoured only while imem_req=1; otherwise ignored.
  - On an honoured ack: push {fetch_pc, imem_rdata}; fetch_pc += 4 with 32-bit wrap (FFFF_FFFC -> 0000_0000).
  - If credit remains, imem_req stays high and imem_addr = new fetch_pc on the next cycle. This gives back-to-back throughput of 1 word/cycle with zero-wait memory.
- Latency: go sampled at edge N -> imem_req=1 after edge N. A zero-wait ack at edge N+1 -> ir_valid=1 after edge N+1.
- Consumer side:
  - Pop on ir_valid & ir_ready.
  - ir_out/ir_pc are driven from the FIFO head.
  - Simultaneous push and pop is legal at any count.
- Redirect (takes priority over everything):
  - FIFO flushed; fetch_pc = {redirect_pc[31:2],2'b00}; HALT/halted cleared.
  - If a request is outstanding, it completes on the bus but its ack is dropped (drop flag). The new request issues after that ack.
  - An ack or pop in the same cycle as a redirect is discarded.
- Halt:
  - HALT_WORD is still pushed and delivered on ir_out.
  - halted=1 on the edge it is popped, and stays 1 until redirect or reset.
- In IDLE, redirect_valid only updates fetch_pc.

Decomposition:
- Package fetch_pkg:
  - State encoding (IDLE, FETCH, HALT).
  - HALT_WORD default and PC_STEP=4.
  - Typedef of the FIFO entry {pc, instr}.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO with push, pop, flush, count and head.
  - Asynchronous active-low reset.

Test Plan:
- Reset then go=1, zero-wait memory returning addr-as-data -> imem_addr 0,4,8 on consecutive cycles; ir_out 0x0,0x4,0x8 with ir_pc equal; ir_valid first high 2 cycles after go.
- ir_ready=0 held with ack always 1 -> exactly 2 words buffered, imem_req drops to 0; ir_ready=1 -> words 0x0,0x4 delivered in order, none lost or duplicated.
- Redirect_pc=0x103 while a request to 0x8 is outstanding (ack delayed 3 cycles) -> 0x8 data dropped, FIFO empty, next imem_addr=0x100, ir_pc=0x100.
- Memory returns 0xFFFFFFFF at address 0xC -> no request issued after the 0xC ack; ir_out=0xFFFFFFFF; halted=1 after it is popped; redirect to 0x0 clears halted and fetching resumes.
- Assert reset=0 mid-burst with ack pending -> all outputs at reset values immediately (asynchronously); stray ack after release ignored; ir_valid stays 0 until go.
- RESET_PC=0xFFFFFFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
